keypad_scanner: RTL



---
 rtl/keypad_pkg.sv | 63 ++++++
 rtl/keypad_if.sv | 24 ++
 rtl/keypad_debounce.sv | 118 +++++++++++
 rtl/keypad_scanner.sv | 114 +++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared key codes, debounce state encoding and key-map helpers for the keypad scanner.
package keypad_pkg;

    localparam logic [4:0] KEY_0    = 5'd0;
    localparam logic [4:0] KEY_1    = 5'd1;
    localparam logic [4:0] KEY_2    = 5'd2;
    localparam logic [4:0] KEY_3    = 5'd3;
    localparam logic [4:0] KEY_4    = 5'd4;
    localparam logic [4:0] KEY_5    = 5'd5;
    localparam logic [4:0] KEY_6    = 5'd6;
    localparam logic [4:0] KEY_7    = 5'd7;
    localparam logic [4:0] KEY_8    = 5'd8;
    localparam logic [4:0] KEY_9    = 5'd9;
    localparam logic [4:0] KEY_A    = 5'd10;
    localparam logic [4:0] KEY_B    = 5'd11;
    localparam logic [4:0] KEY_C    = 5'd12;
    localparam logic [4:0] KEY_D    = 5'd13;
    localparam logic [4:0] KEY_STAR = 5'd14;
    localparam logic [4:0] KEY_HASH = 5'd15;
    localparam logic [4:0] KEY_NONE = 5'd31;

    typedef enum logic [1:0] {
        REL,
        PWAIT,
        PRESSED,
        RWAIT
    } db_state_e;

    function automatic logic [4:0] key_code(input logic [1:0] row,
                                            input logic [1:0] col);
        logic [4:0] code;
        unique case ({row, col})
            4'd0:  code = KEY_1;
            4'd1:  code = KEY_2;
            4'd2:  code = KEY_3;
            4'd3:  code = KEY_A;
            4'd4:  code = KEY_4;
            4'd5:  code = KEY_5;
            4'd6:  code = KEY_6;
            4'd7:  code = KEY_B;
            4'd8:  code = KEY_7;
            4'd9:  code = KEY_8;
            4'd10: code = KEY_9;
            4'd11: code = KEY_C;
            4'd12: code = KEY_STAR;
            4'd13: code = KEY_0;
            4'd14: code = KEY_HASH;
            4'd15: code = KEY_D;
        endcase
        return code;
    endfunction

    // Lowest active column wins; caller guarantees at least one bit set.
    function automatic logic [1:0] first_col(input logic [3:0] hits);
        logic [1:0] col;
        if (hits[0])      col = 2'd0;
        else if (hits[1]) col = 2'd1;
        else if (hits[2]) col = 2'd2;
        else              col = 2'd3;
        return col;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad matrix pins plus the accepted-key bundle handed to game control.
interface keypad_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [4:0] key;
    logic       keypad_pressed;
    logic       key_strobe;

    modport master (
        output row_n,
        output key,
        output keypad_pressed,
        output key_strobe,
        input  col_n
    );

    modport slave (
        input  row_n,
        input  key,
        input  keypad_pressed,
        input  key_strobe,
        output col_n
    );
endinterface

// File: rtl/keypad_debounce.sv
// Debounce FSM: accepts a press or release after DEBOUNCE_SCANS identical full scans.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_end_i,
    input  logic [4:0] result_i,
    output logic [4:0] key_o,
    output logic       pressed_o,
    output logic       strobe_o
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DB  = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam bit SINGLE = (DEBOUNCE_SCANS == 1);

    db_state_e     state_q, state_d;
    logic [4:0]    cand_q, cand_d;
    logic [4:0]    key_q, key_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          pressed_q, pressed_d;
    logic          strobe_q, strobe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= REL;
            cand_q    <= KEY_NONE;
            key_q     <= KEY_NONE;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            key_q     <= key_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            strobe_q  <= strobe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        key_d     = key_q;
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        strobe_d  = 1'b0;
        cnt_inc   = cnt_q + ONE;
        if (scan_end_i) begin
            unique case (state_q)
                REL: begin
                    if (result_i != KEY_NONE) begin
                        cand_d = result_i;
                        cnt_d  = ONE;
                        if (SINGLE) begin
                            state_d   = PRESSED;
                            key_d     = result_i;
                            pressed_d = 1'b1;
                            strobe_d  = 1'b1;
                        end else begin
                            state_d = PWAIT;
                        end
                    end
                end
                PWAIT: begin
                    if (result_i == KEY_NONE) begin
                        state_d = REL;
                        cnt_d   = '0;
                    end else if (result_i == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB) begin
                            state_d   = PRESSED;
                            key_d     = cand_q;
                            pressed_d = 1'b1;
                            strobe_d  = 1'b1;
                        end
                    end else begin
                        cand_d = result_i;
                        cnt_d  = ONE;
                    end
                end
                PRESSED: begin
                    // A different key while held is ignored until release.
                    if (result_i == KEY_NONE) begin
                        cnt_d = ONE;
                        if (SINGLE) begin
                            state_d   = REL;
                            pressed_d = 1'b0;
                        end else begin
                            state_d = RWAIT;
                        end
                    end
                end
                RWAIT: begin
                    if (result_i == KEY_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB) begin
                            state_d   = REL;
                            pressed_d = 1'b0;
                        end
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = REL;
            endcase
        end
    end

    assign key_o     = key_q;
    assign pressed_o = pressed_q;
    assign strobe_o  = strobe_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with column synchroniser, feeding the debounce FSM.
// Build option KEYPAD_GHOST_REJECT_EN: scans with two or more keys down read as no key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    keypad_if.master kp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    row_n_q, row_n_d;
    logic [3:0]    row_hits;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    row_q, row_d;
    logic          hit_q, hit_d, acc_hit;
    logic [4:0]    code_q, code_d, acc_code;
    logic [4:0]    result;
    logic          sample, scan_end, row_any;
`ifdef KEYPAD_GHOST_REJECT_EN
    logic          multi_q, multi_d, acc_multi, row_multi;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            row_n_q <= 4'b1110;
            div_q   <= '0;
            row_q   <= 2'd0;
            hit_q   <= 1'b0;
            code_q  <= KEY_NONE;
        end else begin
            sync1_q <= kp.col_n;
            sync2_q <= sync1_q;
            row_n_q <= row_n_d;
            div_q   <= div_d;
            row_q   <= row_d;
            hit_q   <= hit_d;
            code_q  <= code_d;
        end
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) multi_q <= 1'b0;
        else        multi_q <= multi_d;
    end
`endif

    always_comb begin
        sample   = (div_q == DIV_LAST);
        row_hits = ~sync2_q;
        row_any  = |row_hits;
        // Rows arrive in index order, so the first hit is the lowest index.
        acc_hit  = hit_q | row_any;
        acc_code = code_q;
        if (!hit_q && row_any) acc_code = key_code(row_q, first_col(row_hits));
`ifdef KEYPAD_GHOST_REJECT_EN
        row_multi = |(row_hits & (row_hits - 4'd1));
        acc_multi = multi_q | (hit_q & row_any) | row_multi;
        result    = (acc_hit && !acc_multi) ? acc_code : KEY_NONE;
`else
        result    = acc_hit ? acc_code : KEY_NONE;
`endif
        scan_end = sample && (row_q == 2'd3);

        div_d   = div_q + DW'(1);
        row_d   = row_q;
        row_n_d = row_n_q;
        hit_d   = hit_q;
        code_d  = code_q;
`ifdef KEYPAD_GHOST_REJECT_EN
        multi_d = multi_q;
`endif
        if (sample) begin
            div_d   = '0;
            row_d   = row_q + 2'd1;
            row_n_d = ~(4'b0001 << row_d);
            hit_d   = acc_hit;
            code_d  = acc_code;
`ifdef KEYPAD_GHOST_REJECT_EN
            multi_d = acc_multi;
`endif
            if (scan_end) begin
                hit_d  = 1'b0;
                code_d = KEY_NONE;
`ifdef KEYPAD_GHOST_REJECT_EN
                multi_d = 1'b0;
`endif
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_end_i(scan_end),
        .result_i  (result),
        .key_o     (kp.key),
        .pressed_o (kp.keypad_pressed),
        .strobe_o  (kp.key_strobe)
    );

    assign kp.row_n = row_n_q;

endmodule
